// File: rtl/snd_fade_ctrl.sv
// snd_fade_ctrl: volume ramp sequencer with soft mute, paced by sample ticks,
// also driving USED and the sample-FIFO pop strobe at the audio sample rate.
module snd_fade_ctrl #(
    parameter int STEP_DIV = 48,
    parameter int DIV_W    = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       smpl_tick,
    input  logic       wr_en,
    input  logic [7:0] wr_target,
    input  logic       wr_fast,
    input  logic       mute_req,
    input  logic       fifo_empty,
    output logic       fifo_rd,
    output logic [7:0] volume,
    output logic       used,
    output logic       busy,
    output logic       done
);
    typedef enum logic [2:0] {IDLE, RAMP_UP, RAMP_DN, MUTING, MUTED} state_t;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(STEP_DIV - 1);
    state_t state, state_n;
    logic [7:0] target, eff, vol_n;
    logic [DIV_W-1:0] div, div_n;
    logic ramping, fast, step, enter_ramp, done_n, used_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            volume <= 8'h00;
            target <= 8'h00;
            div    <= '0;
            used   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            volume <= vol_n;
            target <= wr_en ? wr_target : target;
            div    <= div_n;
            used   <= used_n;
            done   <= done_n;
        end
    end

    // A write cycle never steps; a fast write bypasses the ramp entirely.
    always_comb begin
        eff     = mute_req ? 8'h00 : target;
        ramping = state inside {RAMP_UP, RAMP_DN, MUTING};
        fast    = wr_en & wr_fast & ~mute_req;
        step    = ramping & ~wr_en & smpl_tick & (div == DIV_MAX) & (volume != eff);
        vol_n   = fast ? wr_target : step ? (volume < eff ? volume + 8'd1 : volume - 8'd1) : volume;
    end

    always_comb begin
        state_n = state;
        if (fast)
            state_n = IDLE;
        else if (!wr_en) begin
            if (state == MUTED)
                state_n = mute_req ? MUTED : (target == 8'h00 ? IDLE : RAMP_UP);
            else if (vol_n == eff)
                state_n = mute_req ? MUTED : IDLE;
            else
                state_n = mute_req ? MUTING : (vol_n < eff ? RAMP_UP : RAMP_DN);
        end
    end

    always_comb begin
        busy       = ramping;
        fifo_rd    = smpl_tick & ~fifo_empty & ~rst & (state != MUTED);
        enter_ramp = ~ramping & (state_n inside {RAMP_UP, RAMP_DN, MUTING});
        div_n      = (fast | enter_ramp) ? '0 :
                     (ramping & ~wr_en & smpl_tick) ? (div == DIV_MAX ? '0 : div + DIV_W'(1)) : div;
        done_n     = fast ? ramping :
                     ~wr_en & (ramping ? (state_n == IDLE || state_n == MUTED)
                                       : (state == IDLE && state_n == MUTED));
        used_n     = (state_n == MUTED && state != MUTED) ? 1'b0 :
                     smpl_tick ? (~fifo_empty & (state != MUTED)) : used;
    end
endmodule

// File: tb/tb_snd_fade_ctrl.sv
// tb_snd_fade_ctrl: directed + random stimulus against a behavioural volume
// model; expected outputs are queued per cycle and checked by a monitor.
module tb_snd_fade_ctrl;
    localparam int S = 4;
    localparam int IDL = 0, RMP = 1, MTD = 2;

    logic clk = 0, rst = 1, smpl_tick = 0, wr_en = 0, wr_fast = 0, mute_req = 0, fifo_empty = 0;
    logic [7:0] wr_target = 0;
    logic fifo_rd, used, busy, done;
    logic [7:0] volume;

    snd_fade_ctrl #(.STEP_DIV(S), .DIV_W(2)) dut (
        .clk(clk), .rst(rst), .smpl_tick(smpl_tick), .wr_en(wr_en), .wr_target(wr_target),
        .wr_fast(wr_fast), .mute_req(mute_req), .fifo_empty(fifo_empty), .fifo_rd(fifo_rd),
        .volume(volume), .used(used), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {bit rd; bit [7:0] vol; bit used; bit done; bit busy;} exp_t;
    exp_t q[$];
    int checks = 0, passed = 0;

    bit m_rst = 1, m_mute = 0, m_empty = 0;
    int md = IDL, mdiv = 0;
    bit [7:0] mv = 0, mt = 0;
    bit mused = 0, mdone = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endfunction

    // Reference: volume walks one LSB toward the effective target every S ticks
    task automatic cyc(input bit t, input bit w = 0, input bit [7:0] g = 0, input bit f = 0);
        exp_t e;
        bit [7:0] eff;
        int was;
        @(negedge clk);
        rst = m_rst; smpl_tick = t; wr_en = w; wr_target = g; wr_fast = f;
        mute_req = m_mute; fifo_empty = m_empty;
        e.rd = t && !m_empty && !m_rst && md != MTD;
        if (m_rst) begin
            mv = 0; mt = 0; mdiv = 0; md = IDL; mused = 0; mdone = 0;
        end else begin
            eff = m_mute ? 8'h00 : mt;
            was = md;
            mdone = 0;
            if (w) begin
                mt = g;
                if (f && !m_mute) begin
                    mdone = (md == RMP); mv = g; md = IDL; mdiv = 0;
                end
            end else if (md == IDL) begin
                if (mv != eff) begin md = RMP; mdiv = 0; end
                else if (m_mute) begin md = MTD; mdone = 1; end
            end else if (md == MTD) begin
                if (!m_mute) begin md = (mt == 0) ? IDL : RMP; mdiv = 0; end
            end else begin
                if (mv != eff && t) begin
                    if (mdiv == S - 1) begin mv = (mv < eff) ? mv + 1 : mv - 1; mdiv = 0; end
                    else mdiv++;
                end
                if (mv == eff) begin md = m_mute ? MTD : IDL; mdone = 1; end
            end
            if (md == MTD && was != MTD) mused = 0;
            else if (t) mused = !m_empty && was != MTD;
        end
        e.vol = mv; e.used = mused; e.done = mdone; e.busy = (md == RMP);
        q.push_back(e);
    endtask

    task automatic ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            cyc(1);
            repeat (gap) cyc(0);
        end
    endtask

    task automatic expect_vol(input string nm, input bit [7:0] v);
        @(posedge clk); #1;
        chk(nm, 32'(volume), 32'(v));
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk); #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("fifo_rd", 32'(fifo_rd), 32'(e.rd));
                @(posedge clk); #1;
                chk("volume", 32'(volume), 32'(e.vol));
                chk("used", 32'(used), 32'(e.used));
                chk("done", 32'(done), 32'(e.done));
                chk("busy", 32'(busy), 32'(e.busy));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        bit w;
        m_rst = 1; cyc(0); cyc(0); m_rst = 0;
        expect_vol("reset_volume", 8'h00);
        cyc(0, 1, 8'h03);
        ticks(13, 1);
        expect_vol("ramp_to_03", 8'h03);
        cyc(0, 1, 8'h80, 1); cyc(0);
        cyc(0, 1, 8'h7E);
        ticks(6, 1);
        cyc(0, 1, 8'h81);
        ticks(12, 1);
        expect_vol("reverse_to_81", 8'h81);
        cyc(0, 1, 8'h40, 1); cyc(0);
        m_mute = 1;
        ticks(8'h40 * S + 4, 0);
        cyc(0, 1, 8'hC0);
        ticks(4, 0);
        expect_vol("muted_holds_00", 8'h00);
        m_mute = 0;
        ticks(8'hC0 * S + 4, 0);
        expect_vol("unmute_to_C0", 8'hC0);
        cyc(0, 1, 8'h10, 1); cyc(0);
        cyc(0, 1, 8'h60);
        ticks(6, 0);
        cyc(0, 1, 8'hFF, 1);
        expect_vol("fast_to_FF", 8'hFF);
        m_empty = 1; cyc(1);
        m_empty = 0; cyc(1);
        cyc(0, 1, 8'h30, 1); cyc(0);
        cyc(0, 1, 8'h40);
        ticks(12, 0);
        m_rst = 1; cyc(0); m_rst = 0;
        expect_vol("reset_mid_ramp", 8'h00);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(149) == 0) m_mute = ~m_mute;
            m_empty = ($urandom_range(4) == 0);
            m_rst = ($urandom_range(999) == 0);
            w = ($urandom_range(39) == 0);
            cyc(1'($urandom_range(1)), w, 8'($urandom), $urandom_range(3) == 0);
        end
        m_rst = 0;
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
